resp_compare_checker: RTL

Synthesizable response checker that sits at the receiving end of the golden-vs-netlist stimulus flow. It accepts two 32-bit response streams, one from the golden model and one from the post-route netlist. Each stream can arrive with a different latency, so the block aligns them in small per-side FIFOs and compares them pairwise. It counts compares and mismatches, captures the first mismatch, and reports pass/fail after a programmed number of compares.

---
 rtl/resp_cmp_pkg.sv | 22 ++
 rtl/resp_fifo.sv | 50 +++++
 rtl/resp_compare_checker.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/resp_cmp_pkg.sv
// Shared types, defaults and helpers for the response compare checker.
package resp_cmp_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_DEPTH   = 4;
    localparam int unsigned DEF_NUM_CMP = 1000;
    localparam int unsigned DEF_CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    // Increment that sticks at the all-ones value of a width-bit counter (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// Small synchronous FIFO used to align one response stream against the other.
module resp_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        head    = mem_q[rptr_q[AW-1:0]];
    end

    // Pointer update; flush and reset both empty the FIFO.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (rst && !flush && do_push) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/resp_compare_checker.sv
// Aligns golden and netlist response streams, compares them pairwise and reports pass/fail.
module resp_compare_checker
    import resp_cmp_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter int unsigned NUM_CMP = DEF_NUM_CMP,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             gold_valid,
    input  logic [WIDTH-1:0] gold_data,
    input  logic             dut_valid,
    input  logic [WIDTH-1:0] dut_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] cmp_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             overflow,
    output logic             first_mm_valid,
    output logic [WIDTH-1:0] first_mm_gold,
    output logic [WIDTH-1:0] first_mm_dut,
    output logic [CNT_W-1:0] first_mm_idx
);

    localparam logic [CNT_W-1:0] NUM_CMP_C = CNT_W'(NUM_CMP);

    chk_state_t       state_q, state_d;
    logic [CNT_W-1:0] cmp_cnt_q, cmp_cnt_d;
    logic [CNT_W-1:0] mm_cnt_q, mm_cnt_d;
    logic             overflow_q, overflow_d;
    logic             pass_q, pass_d;
    logic             fmm_valid_q, fmm_valid_d;
    logic [WIDTH-1:0] fmm_gold_q, fmm_gold_d;
    logic [WIDTH-1:0] fmm_dut_q, fmm_dut_d;
    logic [CNT_W-1:0] fmm_idx_q, fmm_idx_d;

    logic             run;
    logic             start_run;
    logic             cmp_fire;
    logic             gold_full, gold_empty, dut_full, dut_empty;
    logic [WIDTH-1:0] gold_head, dut_head;
    logic             ovf_event;

    // Push/pop qualification shared by both FIFOs and the FSM.
    always_comb begin
        run       = (state_q == RUN);
        start_run = start && (state_q != RUN);
        cmp_fire  = run && !gold_empty && !dut_empty;
        // A full FIFO still accepts a push when it is popped on the same edge.
        ovf_event = run && ((gold_valid && gold_full && !cmp_fire) ||
                            (dut_valid && dut_full && !cmp_fire));
    end

    resp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_gold_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (start_run),
        .push      (run && gold_valid),
        .push_data (gold_data),
        .pop       (cmp_fire),
        .full      (gold_full),
        .empty     (gold_empty),
        .head      (gold_head)
    );

    resp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_dut_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (start_run),
        .push      (run && dut_valid),
        .push_data (dut_data),
        .pop       (cmp_fire),
        .full      (dut_full),
        .empty     (dut_empty),
        .head      (dut_head)
    );

    // Next-state: run control, counters, first-mismatch capture and verdict.
    always_comb begin
        state_d     = state_q;
        cmp_cnt_d   = cmp_cnt_q;
        mm_cnt_d    = mm_cnt_q;
        overflow_d  = overflow_q;
        pass_d      = pass_q;
        fmm_valid_d = fmm_valid_q;
        fmm_gold_d  = fmm_gold_q;
        fmm_dut_d   = fmm_dut_q;
        fmm_idx_d   = fmm_idx_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    cmp_cnt_d   = '0;
                    mm_cnt_d    = '0;
                    overflow_d  = 1'b0;
                    pass_d      = 1'b0;
                    fmm_valid_d = 1'b0;
                    fmm_gold_d  = '0;
                    fmm_dut_d   = '0;
                    fmm_idx_d   = '0;
                end
            end
            RUN: begin
                if (ovf_event) overflow_d = 1'b1;
                if (cmp_fire) begin
                    cmp_cnt_d = cmp_cnt_q + 1'b1;
                    if (gold_head != dut_head) begin
                        mm_cnt_d = CNT_W'(sat_inc(32'(mm_cnt_q), CNT_W));
                        if (!fmm_valid_q) begin
                            fmm_valid_d = 1'b1;
                            fmm_gold_d  = gold_head;
                            fmm_dut_d   = dut_head;
                            fmm_idx_d   = cmp_cnt_q;
                        end
                    end
                    if (cmp_cnt_d == NUM_CMP_C) begin
                        state_d = DONE;
                        // Verdict includes a mismatch or overflow on this final edge.
                        pass_d  = (mm_cnt_d == '0) && !overflow_d;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            cmp_cnt_q   <= '0;
            mm_cnt_q    <= '0;
            overflow_q  <= 1'b0;
            pass_q      <= 1'b0;
            fmm_valid_q <= 1'b0;
            fmm_gold_q  <= '0;
            fmm_dut_q   <= '0;
            fmm_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmp_cnt_q   <= cmp_cnt_d;
            mm_cnt_q    <= mm_cnt_d;
            overflow_q  <= overflow_d;
            pass_q      <= pass_d;
            fmm_valid_q <= fmm_valid_d;
            fmm_gold_q  <= fmm_gold_d;
            fmm_dut_q   <= fmm_dut_d;
            fmm_idx_q   <= fmm_idx_d;
        end
    end

    // Output mapping.
    always_comb begin
        busy           = (state_q == RUN);
        done           = (state_q == DONE);
        pass           = pass_q;
        cmp_cnt        = cmp_cnt_q;
        mismatch_cnt   = mm_cnt_q;
        overflow       = overflow_q;
        first_mm_valid = fmm_valid_q;
        first_mm_gold  = fmm_gold_q;
        first_mm_dut   = fmm_dut_q;
        first_mm_idx   = fmm_idx_q;
    end

endmodule
